// File: rtl/legv8_instr_encoder.sv
// LEGv8 instruction encoder: packs op/register/immediate fields into 32-bit words
// tagged with their instruction-memory byte address, with range checking and error count.
module legv8_instr_encoder #(
    parameter int unsigned             ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]       BASE_ADDR = '0,
    parameter int unsigned             ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_op,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rn,
    input  logic [4:0]           in_rm,
    input  logic [31:0]          in_imm,
    input  logic                 addr_load,
    input  logic [ADDR_W-1:0]    addr_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [4:0] {
        OP_B    = 5'd0,  OP_BL   = 5'd1,  OP_CBZ  = 5'd2,  OP_CBNZ = 5'd3,
        OP_ADDI = 5'd4,  OP_SUBI = 5'd5,  OP_ANDI = 5'd6,  OP_ORRI = 5'd7,
        OP_EORI = 5'd8,  OP_MOVZ = 5'd9,  OP_ADD  = 5'd10, OP_SUB  = 5'd11,
        OP_AND  = 5'd12, OP_ORR  = 5'd13, OP_EOR  = 5'd14, OP_LDUR = 5'd15,
        OP_STUR = 5'd16
    } op_e;

    logic [ADDR_W-1:0] addr_cnt;
    logic [31:0]       enc;
    logic              enc_err;
    logic              accept;
    logic              fits_s26, fits_s19, fits_s9, fits_u12, fits_movz;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A signed value fits in N bits when all bits from N-1 upward equal the sign
    assign fits_s26  = (in_imm[31:25] == '0) || (in_imm[31:25] == '1);
    assign fits_s19  = (in_imm[31:18] == '0) || (in_imm[31:18] == '1);
    assign fits_s9   = (in_imm[31:8]  == '0) || (in_imm[31:8]  == '1);
    assign fits_u12  = (in_imm[31:12] == '0);
    assign fits_movz = (in_imm[31:18] == '0);

    always_comb begin
        enc     = '0;
        enc_err = 1'b0;
        case (op_e'(in_op))
            OP_B:    begin enc_err = !fits_s26; enc = {6'b000101, in_imm[25:0]}; end
            OP_BL:   begin enc_err = !fits_s26; enc = {6'b100101, in_imm[25:0]}; end
            OP_CBZ:  begin enc_err = !fits_s19; enc = {8'b10110100, in_imm[18:0], in_rd}; end
            OP_CBNZ: begin enc_err = !fits_s19; enc = {8'b10110101, in_imm[18:0], in_rd}; end
            OP_ADDI: begin enc_err = !fits_u12; enc = {10'b1001000100, in_imm[11:0], in_rn, in_rd}; end
            OP_SUBI: begin enc_err = !fits_u12; enc = {10'b1101000100, in_imm[11:0], in_rn, in_rd}; end
            OP_ANDI: begin enc_err = !fits_u12; enc = {10'b1001001000, in_imm[11:0], in_rn, in_rd}; end
            OP_ORRI: begin enc_err = !fits_u12; enc = {10'b1011001000, in_imm[11:0], in_rn, in_rd}; end
            OP_EORI: begin enc_err = !fits_u12; enc = {10'b1101001000, in_imm[11:0], in_rn, in_rd}; end
            OP_MOVZ: begin enc_err = !fits_movz; enc = {9'b110100101, in_imm[17:16], in_imm[15:0], in_rd}; end
            OP_ADD:  enc = {11'b10001011000, in_rm, 6'b000000, in_rn, in_rd};
            OP_SUB:  enc = {11'b11001011000, in_rm, 6'b000000, in_rn, in_rd};
            OP_AND:  enc = {11'b10001010000, in_rm, 6'b000000, in_rn, in_rd};
            OP_ORR:  enc = {11'b10101010000, in_rm, 6'b000000, in_rn, in_rd};
            OP_EOR:  enc = {11'b11001010000, in_rm, 6'b000000, in_rn, in_rd};
            OP_LDUR: begin enc_err = !fits_s9; enc = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd}; end
            OP_STUR: begin enc_err = !fits_s9; enc = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd}; end
            default: enc_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
            out_err   <= 1'b0;
            err_count <= '0;
            addr_cnt  <= BASE_ADDR;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_instr <= enc_err ? '0 : enc;
                out_addr  <= addr_cnt;
                out_err   <= enc_err;
                if (enc_err && (err_count != '1))
                    err_count <= err_count + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // An explicit load wins over the post-accept increment
            if (addr_load)
                addr_cnt <= addr_value;
            else if (accept && !enc_err)
                addr_cnt <= addr_cnt + ADDR_W'(4);
        end
    end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Directed bench for legv8_instr_encoder: encoding table, backpressure,
// address load/wrap, error saturation and asynchronous reset.
module tb_legv8_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op, in_rd, in_rn, in_rm;
    logic [31:0] in_imm;
    logic        addr_load;
    logic [31:0] addr_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_addr;
    int          exp_errs;
    logic [31:0] held_instr, held_addr;

    always #5 clk = ~clk;

    legv8_instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .addr_load(addr_load), .addr_value(addr_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .err_count(err_count)
    );

    typedef struct {
        string       name;
        logic [4:0]  op, rd, rn, rm;
        logic [31:0] imm;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [31:0] imm);
        in_valid = 1'b1;
        in_op = op; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm;
    endtask

    function automatic void note_err();
        exp_errs = (exp_errs >= 255) ? 255 : exp_errs + 1;
    endfunction

    initial begin
        vecs.push_back('{"addi",      5'd4,  5'd1,  5'd2,  5'd0,  32'd5,        32'h91001441, 1'b0});
        vecs.push_back('{"add",       5'd10, 5'd3,  5'd1,  5'd2,  32'd0,        32'h8B020023, 1'b0});
        vecs.push_back('{"ldur",      5'd15, 5'd4,  5'd5,  5'd0,  32'hFFFFFFF8, 32'hF85F80A4, 1'b0});
        vecs.push_back('{"b_neg1",    5'd0,  5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 32'h17FFFFFF, 1'b0});
        vecs.push_back('{"addi_4096", 5'd4,  5'd1,  5'd2,  5'd0,  32'd4096,     32'h0,        1'b1});
        vecs.push_back('{"op20",      5'd20, 5'd1,  5'd2,  5'd3,  32'd0,        32'h0,        1'b1});
        vecs.push_back('{"bl",        5'd1,  5'd0,  5'd0,  5'd0,  32'd1,        32'h94000001, 1'b0});
        vecs.push_back('{"cbz",       5'd2,  5'd3,  5'd9,  5'd0,  32'd2,        32'hB4000043, 1'b0});
        vecs.push_back('{"cbnz",      5'd3,  5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 32'hB5FFFFE0, 1'b0});
        vecs.push_back('{"subi_4095", 5'd5,  5'd0,  5'd0,  5'd0,  32'd4095,     32'hD13FFC00, 1'b0});
        vecs.push_back('{"andi",      5'd6,  5'd1,  5'd1,  5'd0,  32'd0,        32'h92000021, 1'b0});
        vecs.push_back('{"orri",      5'd7,  5'd4,  5'd5,  5'd0,  32'h10,       32'hB20040A4, 1'b0});
        vecs.push_back('{"eori",      5'd8,  5'd2,  5'd3,  5'd0,  32'h800,      32'hD2200062, 1'b0});
        vecs.push_back('{"movz",      5'd9,  5'd7,  5'd0,  5'd0,  32'h00031234, 32'hD2E24687, 1'b0});
        vecs.push_back('{"sub",       5'd11, 5'd1,  5'd2,  5'd3,  32'd0,        32'hCB030041, 1'b0});
        vecs.push_back('{"and",       5'd12, 5'd0,  5'd0,  5'd31, 32'd0,        32'h8A1F0000, 1'b0});
        vecs.push_back('{"orr",       5'd13, 5'd5,  5'd6,  5'd7,  32'd0,        32'hAA0700C5, 1'b0});
        vecs.push_back('{"eor",       5'd14, 5'd31, 5'd31, 5'd31, 32'd0,        32'hCA1F03FF, 1'b0});
        vecs.push_back('{"stur_255",  5'd16, 5'd31, 5'd31, 5'd0,  32'd255,      32'hF80FF3FF, 1'b0});
        vecs.push_back('{"b_min",     5'd0,  5'd0,  5'd0,  5'd0,  32'hFE000000, 32'h16000000, 1'b0});
        vecs.push_back('{"b_over",    5'd0,  5'd0,  5'd0,  5'd0,  32'h02000000, 32'h0,        1'b1});
        vecs.push_back('{"cbz_over",  5'd2,  5'd1,  5'd0,  5'd0,  32'h00040000, 32'h0,        1'b1});
        vecs.push_back('{"cbz_min",   5'd2,  5'd1,  5'd0,  5'd0,  32'hFFFC0000, 32'hB4800001, 1'b0});
        vecs.push_back('{"ldur_m257", 5'd15, 5'd0,  5'd0,  5'd0,  32'hFFFFFEFF, 32'h0,        1'b1});
        vecs.push_back('{"ldur_m256", 5'd15, 5'd0,  5'd0,  5'd0,  32'hFFFFFF00, 32'hF8500000, 1'b0});
        vecs.push_back('{"stur_256",  5'd16, 5'd0,  5'd0,  5'd0,  32'd256,      32'h0,        1'b1});
        vecs.push_back('{"movz_over", 5'd9,  5'd0,  5'd0,  5'd0,  32'h00040000, 32'h0,        1'b1});
        vecs.push_back('{"op31",      5'd31, 5'd0,  5'd0,  5'd0,  32'd0,        32'h0,        1'b1});

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; addr_load = 1'b0; addr_value = '0;
        in_op = '0; in_rd = '0; in_rn = '0; in_rm = '0; in_imm = '0;
        exp_addr = 32'h0; exp_errs = 0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_addr",  out_addr, 0);
        check("rst_out_err",   out_err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_in_ready",  in_ready, 1);
        reset = 1'b0;

        // Encoding table, one request per cycle with the consumer always ready
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm);
            @(negedge clk);
            check({vecs[i].name, "_valid"}, out_valid, 1);
            check({vecs[i].name, "_instr"}, out_instr, vecs[i].instr);
            check({vecs[i].name, "_addr"},  out_addr, exp_addr);
            check({vecs[i].name, "_err"},   out_err, vecs[i].err);
            if (vecs[i].err) note_err(); else exp_addr = exp_addr + 4;
            check({vecs[i].name, "_errcnt"}, err_count, exp_errs);
            in_valid = 1'b0;
        end
        @(negedge clk);
        check("drain_valid", out_valid, 0);

        // Backpressure: word held stable for 3 cycles, next request waits
        out_ready = 1'b0;
        drive(5'd10, 5'd3, 5'd1, 5'd2, 32'd0);
        @(negedge clk);
        check("bp_first_valid", out_valid, 1);
        check("bp_first_instr", out_instr, 32'h8B020023);
        held_instr = out_instr; held_addr = out_addr;
        check("bp_first_addr", out_addr, exp_addr);
        exp_addr = exp_addr + 4;
        drive(5'd13, 5'd5, 5'd6, 5'd7, 32'd0);
        for (int c = 0; c < 3; c++) begin
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_instr", out_instr, 32'h8B020023);
            check("bp_hold_addr",  out_addr, held_addr);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", in_ready, 1);
        @(negedge clk);
        check("bp_second_instr", out_instr, 32'hAA0700C5);
        check("bp_second_addr",  out_addr, exp_addr);
        exp_addr = exp_addr + 4;
        drive(5'd8, 5'd2, 5'd3, 5'd0, 32'h800);
        @(negedge clk);
        check("bp_third_valid", out_valid, 1);
        check("bp_third_instr", out_instr, 32'hD2200062);
        check("bp_third_addr",  out_addr, exp_addr);
        exp_addr = exp_addr + 4;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_clear_valid", out_valid, 0);

        // Address load in the same cycle as an accept
        drive(5'd4, 5'd1, 5'd2, 5'd0, 32'd5);
        addr_load = 1'b1; addr_value = 32'h100;
        @(negedge clk);
        addr_load = 1'b0;
        check("ld_same_addr", out_addr, exp_addr);
        drive(5'd4, 5'd1, 5'd2, 5'd0, 32'd5);
        @(negedge clk);
        check("ld_next_addr", out_addr, 32'h100);
        in_valid = 1'b0;
        addr_load = 1'b1; addr_value = 32'hFFFFFFFC;
        @(negedge clk);
        addr_load = 1'b0;
        check("ld_idle_valid", out_valid, 0);
        drive(5'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
        @(negedge clk);
        check("wrap_top_addr", out_addr, 32'hFFFFFFFC);
        drive(5'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
        @(negedge clk);
        check("wrap_zero_addr", out_addr, 32'h0);
        in_valid = 1'b0;

        // Saturate the error counter with back-to-back illegal ops
        drive(5'd17, 5'd0, 5'd0, 5'd0, 32'd0);
        for (int k = 0; k < 260; k++) begin
            @(negedge clk);
            note_err();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("sat_err_count", err_count, exp_errs);
        check("sat_is_max", err_count, 8'hFF);
        drive(5'd10, 5'd3, 5'd1, 5'd2, 32'd0);
        @(negedge clk);
        check("post_err_addr", out_addr, 32'h4);
        in_valid = 1'b0;

        // Asynchronous reset with a held word
        out_ready = 1'b0;
        drive(5'd10, 5'd3, 5'd1, 5'd2, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("prerst_valid", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_errcnt", err_count, 0);
        check("async_rst_instr", out_instr, 0);
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        drive(5'd4, 5'd1, 5'd2, 5'd0, 32'd5);
        @(negedge clk);
        check("postrst_addr",  out_addr, 32'h0);
        check("postrst_instr", out_instr, 32'h91001441);
        in_valid = 1'b0;
        @(negedge clk);
        check("postrst_nodup", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
